// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-stream handshake and serial-side status of the UART transmitter.
//   tx_vld   producer -> transmitter : tx_data valid this cycle
//   tx_data  producer -> transmitter : byte to send
//   tx_rdy   transmitter -> producer : FIFO can accept this cycle
//   tx       transmitter -> pin      : serial line (idle high)
//   tx_busy  transmitter -> producer : FIFO non-empty or frame in progress
// The master modport is the byte producer; the slave modport is uart_tx.
interface uart_tx_if;
  logic       tx_vld;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic       tx;
  logic       tx_busy;

  modport master (
    output tx_vld,
    output tx_data,
    input  tx_rdy,
    input  tx,
    input  tx_busy
  );

  modport slave (
    input  tx_vld,
    input  tx_data,
    output tx_rdy,
    output tx,
    output tx_busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small input FIFO.
//   Bytes enter through a valid/ready handshake and are sent as a start bit (0),
//   eight data bits LSB first and a stop bit (1). One bit lasts DIV_CNT+1 clocks.
//   Consecutive queued bytes are sent with no idle gap between frames.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset; aborts any frame, line returns high
//   bus    slave side of uart_tx_if (tx_vld, tx_data, tx_rdy, tx, tx_busy)
module uart_tx #(
  parameter logic [9:0] DIV_CNT    = 10'd867,
  parameter int         FIFO_DEPTH = 4,
  parameter int         FIFO_AW    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [9:0]         div_cnt;
  logic [2:0]         bit_cnt;
  logic               tx_q;
  logic [7:0]         shift_q;

  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic               push;
  logic               pop;
  logic               bit_end;
  logic               fifo_nempty;

  assign bit_end     = (div_cnt == DIV_CNT);
  assign fifo_nempty = (count != '0);
  assign push        = bus.tx_vld && bus.tx_rdy;

  // A byte leaves the FIFO only on the edge that enters START: either from IDLE,
  // or straight out of the last clock of a stop bit when more data is queued.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = fifo_nempty;
      STOP:    pop = bit_end && fifo_nempty;
      default: pop = 1'b0;
    endcase
  end

  assign bus.tx_rdy  = (count != FULL_CNT);
  assign bus.tx_busy = (state != IDLE) || fifo_nempty;
  assign bus.tx      = tx_q;

  // FIFO control: pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage and shift register hold data only, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= fifo_mem[rd_ptr];
    end else if (state == DATA && bit_end) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  // Frame sequencer. tx_q is registered and always set to the level of the bit
  // that starts on this edge, so the pin changes exactly at bit boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_q    <= 1'b1;
          div_cnt <= '0;
          if (fifo_nempty) begin
            state <= START;
            tx_q  <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              // shift_q shifts on this same edge, so the next bit is shift_q[1] now.
              tx_q <= shift_q[1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (fifo_nempty) begin
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          tx_q    <= 1'b1;
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
//   Main instance uses 10-clock bits. A second instance at the default divider is
//   decoded by a bench-side serial sampler for the loopback sequence.
module tb_uart_tx;
  localparam logic [9:0] DIV_T = 10'd9;
  localparam int BIT   = 10;
  localparam int FRAME = 10 * BIT;
  localparam int DEPTH = 4;
  localparam int BIT_L = 868;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if bus ();
  uart_tx_if bus2 ();

  uart_tx #(.DIV_CNT(DIV_T), .FIFO_DEPTH(4), .FIFO_AW(2)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  uart_tx #(.DIV_CNT(10'd867), .FIFO_DEPTH(4), .FIFO_AW(2)) u_dut_loop (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic       exp_tx;
    logic       exp_rdy;
    logic       exp_busy;
  } vec_t;

  // Reference model: every accepted byte becomes a frame occupying
  // [start, start+FRAME) on the line; start is one clock after acceptance or the
  // end of the previous frame, whichever is later.
  typedef struct {
    int         acc;
    int         start;
    logic [7:0] data;
  } frame_t;

  frame_t q[$];
  int     free_at = 0;
  int     cyc     = 0;
  int     vec_cnt = 0;
  int     err_cnt = 0;

  function automatic logic m_tx(input int t);
    foreach (q[i]) begin
      if (t >= q[i].start && t < q[i].start + FRAME) begin
        int idx;
        idx = (t - q[i].start) / BIT;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return q[i].data[idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic int m_entries(input int t);
    int n = 0;
    foreach (q[i]) if (q[i].acc <= t && q[i].start > t) n++;
    return n;
  endfunction

  function automatic logic m_busy(input int t);
    foreach (q[i]) if (q[i].acc <= t && t < q[i].start + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of input, advance one clock, compare against the model.
  task automatic step(input logic v, input logic [7:0] d, output bit acc);
    int st;
    bus.tx_vld  = v;
    bus.tx_data = d;
    acc = v && (m_entries(cyc) != DEPTH);
    @(posedge clk);
    cyc++;
    if (acc) begin
      st = (cyc + 1 > free_at) ? cyc + 1 : free_at;
      q.push_back('{cyc, st, d});
      free_at = st + FRAME;
    end
    #1;
    chk("tx",      bus.tx,      m_tx(cyc));
    chk("tx_rdy",  bus.tx_rdy,  (m_entries(cyc) != DEPTH));
    chk("tx_busy", bus.tx_busy, m_busy(cyc));
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
  endtask

  // Asynchronous reset mid-cycle, held with tx_vld high, then released.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tx_async",   bus.tx,      1'b1);
    chk("rst_rdy_async",  bus.tx_rdy,  1'b1);
    chk("rst_busy_async", bus.tx_busy, 1'b0);
    bus.tx_vld  = 1'b1;
    bus.tx_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_tx",   bus.tx,      1'b1);
      chk("rst_rdy",  bus.tx_rdy,  1'b1);
      chk("rst_busy", bus.tx_busy, 1'b0);
    end
    bus.tx_vld = 1'b0;
    rst_n      = 1'b1;
    q.delete();
    free_at = 0;
  endtask

  task automatic rx_byte(output logic [7:0] b);
    int k;
    b = '0;
    k = 0;
    while (bus2.tx !== 1'b0 && k < 20000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("rx_start_seen", 8'(k < 20000), 8'd1);
    repeat (BIT_L / 2) @(posedge clk);
    #1;
    chk("rx_start_low", bus2.tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_L) @(posedge clk);
      #1;
      b[i] = bus2.tx;
    end
    repeat (BIT_L) @(posedge clk);
    #1;
    chk("rx_stop_high", bus2.tx, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[13];
    bit         a;
    int         n;
    int         k;
    logic [7:0] six[6];
    logic [7:0] rb;

    tbl[0]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1};

    bus.tx_vld   = 1'b0;
    bus.tx_data  = 8'h00;
    bus2.tx_vld  = 1'b0;
    bus2.tx_data = 8'h00;

    // Reset behaviour, accept-to-start latency, FIFO fill and full back-pressure.
    foreach (tbl[i]) begin
      rst_n       = tbl[i].rst;
      bus.tx_vld  = tbl[i].vld;
      bus.tx_data = tbl[i].data;
      @(posedge clk);
      cyc++;
      #1;
      chk("tbl_tx",   bus.tx,      tbl[i].exp_tx);
      chk("tbl_rdy",  bus.tx_rdy,  tbl[i].exp_rdy);
      chk("tbl_busy", bus.tx_busy, tbl[i].exp_busy);
    end

    // Reset during the start bit with a full FIFO: everything must be discarded.
    do_reset();
    idle(5);

    // Single byte 0xA5.
    step(1'b1, 8'hA5, a);
    idle(110);

    // Back-to-back 0x00 then 0xFF.
    step(1'b1, 8'h00, a);
    step(1'b1, 8'hFF, a);
    idle(210);

    // Six bytes with tx_vld held high; FIFO goes full after the fifth accept.
    six = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h96, 8'h3F};
    n = 0;
    k = 0;
    while (n < 6 && k < 2000) begin
      step(1'b1, six[n], a);
      if (a) begin
        n++;
        if (n == 5) chk("rdy_low_after_5th", bus.tx_rdy, 1'b0);
      end
      k++;
    end
    chk("six_accepted", 8'(n), 8'd6);
    idle(650);

    // Reset in the middle of DATA of 0x3C, then a clean 0x81.
    step(1'b1, 8'h3C, a);
    idle(25);
    chk("pre_reset_low", bus.tx, 1'b0);
    do_reset();
    step(1'b1, 8'h81, a);
    idle(110);

    // Randomized traffic: a heavy phase that saturates the FIFO, then a sparse one.
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 1) == 1, 8'($urandom), a);
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 39) == 0, 8'($urandom), a);
    idle(600);

    // Loopback at the default divider.
    @(posedge clk);
    #1;
    bus2.tx_vld  = 1'b1;
    bus2.tx_data = 8'h55;
    @(posedge clk);
    #1;
    bus2.tx_data = 8'hC3;
    @(posedge clk);
    #1;
    bus2.tx_vld = 1'b0;
    rx_byte(rb);
    chk("loop_byte0", rb, 8'h55);
    rx_byte(rb);
    chk("loop_byte1", rb, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
